// File: rtl/tdes_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tdes_sequencer
// Purpose  : Runs one iterative DES core three times per block (two-key 3DES:
//            EDE / DED). Define THREE_KEY_EN to add in_key3 for pass 2.
// Revision : 1.0  initial release
// ============================================================================
module tdes_sequencer #(
    parameter int DATA_W  = 64,
    parameter int KEY_W   = 56,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_e,
    input  logic [KEY_W-1:0]  in_key1,
    input  logic [KEY_W-1:0]  in_key2,
`ifdef THREE_KEY_EN
    input  logic [KEY_W-1:0]  in_key3,
`endif
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              busy,
    output logic              des_start,
    output logic              des_e,
    output logic [KEY_W-1:0]  des_key,
    output logic [DATA_W-1:0] des_in,
    input  logic              des_done,
    input  logic [DATA_W-1:0] des_out
);

    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_pass;
    logic                r_e;
    logic [KEY_W-1:0]    r_key1;
    logic [KEY_W-1:0]    r_key2;
`ifdef THREE_KEY_EN
    logic [KEY_W-1:0]    r_key3;
`endif
    logic [DATA_W-1:0]   r_work;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_err;
    logic                w_core_active;
    logic [KEY_W-1:0]    w_pass_key;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pass  <= 2'd0;
            r_e     <= 1'b0;
            r_key1  <= '0;
            r_key2  <= '0;
`ifdef THREE_KEY_EN
            r_key3  <= '0;
`endif
            r_work  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_e    <= in_e;
                        r_key1 <= in_key1;
                        r_key2 <= in_key2;
`ifdef THREE_KEY_EN
                        r_key3 <= in_key3;
`endif
                        r_work <= in_data;
                        r_pass <= 2'd0;
                        r_err  <= 1'b0;
                    end
                end
                ISSUE: r_cnt <= '0;
                WAIT: begin
                    if (des_done) begin
                        r_work <= des_out;
                        if (r_pass != 2'd2) begin
                            r_pass <= r_pass + 2'd1;
                        end
                    end else if (r_cnt == c_cnt_last) begin
                        // Abort keeps the last good intermediate block in r_work.
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (in_valid && in_ready) w_state_nxt = ISSUE;
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                if (des_done) begin
                    w_state_nxt = (r_pass == 2'd2) ? OUT : ISSUE;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = OUT;
                end
            end
            OUT:   if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Middle pass uses key2 in the opposite direction; outer passes use key1 (or key3).
    always_comb begin
        w_pass_key = r_key1;
        if (r_pass == 2'd1) begin
            w_pass_key = r_key2;
        end else if (r_pass == 2'd2) begin
`ifdef THREE_KEY_EN
            w_pass_key = r_key3;
`else
            w_pass_key = r_key1;
`endif
        end
    end

    assign w_core_active = (r_state == ISSUE) || (r_state == WAIT);

    // Gating with rst_n keeps in_ready low for the whole reset interval.
    assign in_ready  = (r_state == IDLE) && rst_n;
    assign busy      = (r_state != IDLE);
    assign des_start = (r_state == ISSUE);
    assign des_e     = w_core_active && ((r_pass == 2'd1) ? ~r_e : r_e);
    assign des_key   = w_core_active ? w_pass_key : '0;
    assign des_in    = w_core_active ? r_work : '0;
    assign out_valid = (r_state == OUT);
    assign out_data  = (r_state == OUT) ? r_work : '0;
    assign out_err   = (r_state == OUT) && r_err;

endmodule
`default_nettype wire

// File: doc/tdes_sequencer.md
Name: tdes_sequencer

Overview:
Controller that time-shares one iterative DES core across the three passes of a two-key Triple-DES operation.
- Encrypt (EDE) order: E(k1), D(k2), E(k1). Decrypt order: D(k1), E(k2), D(k1).
- Accepts one 64-bit block per valid/ready handshake and drives the core with a start/done handshake.
- Returns the result on a valid/ready output port.
- Sits between the host-side block interface and the `des` core in the tripledes datapath.

Parameters:
DATA_W, 64, block width
KEY_W, 56, key width (parity bits already stripped)
TIMEOUT, 256, max cycles waited for des_done per pass before aborting

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  request valid
in_ready  out  1  sequencer can accept request
in_e  in  1  1 = encrypt, 0 = decrypt
in_key1  in  KEY_W  key 1
in_key2  in  KEY_W  key 2
in_data  in  DATA_W  input block
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  result block
out_err  out  1  result aborted by core timeout
busy  out  1  high in any state except IDLE
des_start  out  1  one-cycle pulse launching a core pass
des_e  out  1  core mode for current pass
des_key  out  KEY_W  core key for current pass
des_in  out  DATA_W  core input block
des_done  in  1  one-cycle pulse, core result ready
des_out  in  DATA_W  core result, valid when des_done=1

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; pass counter and timeout counter cleared.
  - All outputs 0: in_ready, out_valid, out_err, busy, des_start, des_e, des_key, des_in, out_data.
  - in_ready rises the first cycle after rst_n=1.
  - Reset mid-operation abandons the block with no output; a late des_done is ignored.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch in_e, keys and in_data into the work register; pass=0; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - des_start=1; des_in = work register.
  - des_key = key1 for pass 0 and 2, key2 for pass 1.
  - des_e = e_latched for pass 0 and 2, ~e_latched for pass 1.
  - Go to WAIT with timeout counter=0.
- WAIT:
  - des_in, des_key and des_e are held stable; des_start=0.
  - On des_done: work register <= des_out.
    - If pass==2, go to OUT with out_err=0.
    - Otherwise pass+1 and go to ISSUE.
  - With no des_done, the counter increments. When the counter reaches TIMEOUT-1 without des_done: out_err=1, work register unchanged, go to OUT.
- des_done outside WAIT is ignored.
- OUT:
  - out_valid=1; out_data = work register; out_err as set. Both held stable until out_ready.
  - On out_ready: out_valid=0, out_err=0, go to IDLE. in_ready returns the next cycle; there is no same-cycle turnaround.
- Latency: with core latency L (des_done L cycles after des_start, L>=1), each pass takes L+1 cycles. Handshake accepted at edge t gives out_valid at cycle t+1+3(L+1).
- Throughput: one block in flight; in_ready=0 while busy.

Optional Feature:
THREE_KEY_EN
- Defined: adds port in_key3 (in, KEY_W). It is latched at accept and used as des_key for pass 2 (three-key 3DES).
- Undefined: port absent; pass 2 reuses key1.

Test Plan:
- Mock core, L=1, in_e=1, key1=56'h1, key2=56'h2: exactly 3 des_start pulses; (des_e, des_key) = (1,1), (0,2), (1,1); out_valid 7 cycles after accept.
- Real DES core, key1=key2=56-bit form of 64'h133457799BBCDFF1, in_data=64'h0123456789ABCDEF, in_e=1 -> out_data=64'h85E813540F0AB405, out_err=0. Same keys with in_e=0 and that ciphertext -> 64'h0123456789ABCDEF.
- out_ready held 0 for 10 cycles after out_valid: out_data and out_valid stable, in_ready=0, no des_start. out_ready=1 -> in_ready=1 on the next cycle.
- Mock core never asserts des_done, TIMEOUT=16: out_valid and out_err=1 at 17 cycles after the first des_start; out_data = original in_data.
- rst_n=0 for 1 cycle during WAIT of pass 1, then a stray des_done: all outputs 0, state IDLE, no out_valid; the next block completes normally.
- With THREE_KEY_EN, key3=56'h3: pass 2 des_key=3. Without it, pass 2 des_key=key1.
